arbiter_8req_hold: RTL and testbench

Registered 8-requester arbiter that shares a single downstream resource (bus, port or datapath slot) among up to eight clients. Each cycle it resolves pending requests either by fixed priority (highest index wins, matching the 8→3 priority encoding used elsewhere in the design) or by round-robin. It holds each grant until the owner releases it or a hold limit expires. All outputs are registered and drive the resource mux select directly.

---
 rtl/arbiter_8req_hold.sv | 139 +++++++++++++
 tb/tb_arbiter_8req_hold.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_8req_hold.sv
// Registered 8-requester arbiter with fixed-priority or round-robin selection,
// grant hold until release, and a MAX_HOLD ownership limit with a timeout pulse.
module arbiter_8req_hold #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

   state_t     state_r, state_nxt_s;
   logic [7:0] gnt_r, gnt_nxt_s;
   logic [2:0] gnt_id_r, gnt_id_nxt_s;
   logic       gnt_valid_r, gnt_valid_nxt_s;
   logic       timeout_r, timeout_nxt_s;
   logic [7:0] hold_cnt_r, hold_cnt_nxt_s;
   logic [2:0] rr_ptr_r, rr_ptr_nxt_s;

   logic       owner_req_s, forced_s, release_s, arb_s;
   logic [7:0] mask_s, cand_s;
   logic       cand_any_s;
   logic [2:0] win_fp_s, win_rr_s, win_s, rr_idx_s;
   logic       rr_found_s;

   // Release decisions; the mask only excludes the owner being forcibly revoked
   assign owner_req_s = req[gnt_id_r];
   assign forced_s    = (state_r == GRANT) && owner_req_s && (hold_cnt_r == MAX_HOLD_C);
   assign release_s   = (state_r == GRANT) && (!owner_req_s || forced_s);
   assign arb_s       = (state_r == IDLE) || release_s;
   assign mask_s      = forced_s ? gnt_r : 8'h00;
   assign cand_s      = req & ~mask_s;
   assign cand_any_s  = |cand_s;

   // Winner selection: highest index, or first set bit after rr_ptr with wrap
   always_comb begin
      win_fp_s   = 3'd0;
      win_rr_s   = 3'd0;
      rr_idx_s   = 3'd0;
      rr_found_s = 1'b0;
      for (int i = 0; i < 8; i++) begin
         win_fp_s = cand_s[i] ? 3'(i) : win_fp_s;
      end
      for (int i = 0; i < 8; i++) begin
         rr_idx_s   = rr_ptr_r + 3'd1 + 3'(i);
         win_rr_s   = (cand_s[rr_idx_s] && !rr_found_s) ? rr_idx_s : win_rr_s;
         rr_found_s = rr_found_s | cand_s[rr_idx_s];
      end
      win_s = mode ? win_rr_s : win_fp_s;
   end

   // State register and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         gnt_r       <= 8'h00;
         gnt_id_r    <= 3'd0;
         gnt_valid_r <= 1'b0;
         timeout_r   <= 1'b0;
         hold_cnt_r  <= 8'd0;
         rr_ptr_r    <= 3'd7;
      end else begin
         state_r     <= state_nxt_s;
         gnt_r       <= gnt_nxt_s;
         gnt_id_r    <= gnt_id_nxt_s;
         gnt_valid_r <= gnt_valid_nxt_s;
         timeout_r   <= timeout_nxt_s;
         hold_cnt_r  <= hold_cnt_nxt_s;
         rr_ptr_r    <= rr_ptr_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            state_nxt_s = cand_any_s ? GRANT : IDLE;
         end
         GRANT: begin
            if (release_s) begin
               state_nxt_s = cand_any_s ? GRANT : IDLE;
            end else begin
               state_nxt_s = GRANT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Next output values: load a winner on arbitration edges, otherwise keep counting
   always_comb begin
      gnt_nxt_s       = gnt_r;
      gnt_id_nxt_s    = gnt_id_r;
      gnt_valid_nxt_s = gnt_valid_r;
      hold_cnt_nxt_s  = hold_cnt_r;
      rr_ptr_nxt_s    = rr_ptr_r;
      timeout_nxt_s   = forced_s;
      if (arb_s) begin
         if (cand_any_s) begin
            gnt_nxt_s       = 8'h01 << win_s;
            gnt_id_nxt_s    = win_s;
            gnt_valid_nxt_s = 1'b1;
            hold_cnt_nxt_s  = 8'd1;
            rr_ptr_nxt_s    = win_s;
         end else begin
            gnt_nxt_s       = 8'h00;
            gnt_id_nxt_s    = 3'd0;
            gnt_valid_nxt_s = 1'b0;
            hold_cnt_nxt_s  = 8'd0;
         end
      end else begin
         if (hold_cnt_r < MAX_HOLD_C) begin
            hold_cnt_nxt_s = hold_cnt_r + 8'd1;
         end else begin
            hold_cnt_nxt_s = hold_cnt_r;
         end
      end
   end

   assign gnt       = gnt_r;
   assign gnt_id    = gnt_id_r;
   assign gnt_valid = gnt_valid_r;
   assign timeout   = timeout_r;

endmodule

// File: tb/tb_arbiter_8req_hold.sv
// Bench for arbiter_8req_hold: three instances (MAX_HOLD 15, 4, 3) on shared stimulus,
// an ownership-level reference model compared every cycle, plus directed literal checks.
module tb_arbiter_8req_hold;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode;
   logic [7:0] req;
   logic [7:0] gnt_w   [3];
   logic [2:0] id_w    [3];
   logic       valid_w [3];
   logic       to_w    [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   arbiter_8req_hold #(.MAX_HOLD(15)) u_h15 (.clk(clk), .rst(rst), .mode(mode), .req(req),
      .gnt(gnt_w[0]), .gnt_id(id_w[0]), .gnt_valid(valid_w[0]), .timeout(to_w[0]));
   arbiter_8req_hold #(.MAX_HOLD(4)) u_h4 (.clk(clk), .rst(rst), .mode(mode), .req(req),
      .gnt(gnt_w[1]), .gnt_id(id_w[1]), .gnt_valid(valid_w[1]), .timeout(to_w[1]));
   arbiter_8req_hold #(.MAX_HOLD(3)) u_h3 (.clk(clk), .rst(rst), .mode(mode), .req(req),
      .gnt(gnt_w[2]), .gnt_id(id_w[2]), .gnt_valid(valid_w[2]), .timeout(to_w[2]));

   // Reference model: owner index (-1 = idle), cycles owned, last winner, timeout flag
   int m_own  [3];
   int m_hold [3];
   int m_rr   [3];
   bit m_to   [3];
   int mh     [3] = '{15, 4, 3};

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_step(input int k);
      int         own;
      int         w;
      bit         forced;
      logic [7:0] c;
      own    = m_own[k];
      forced = (own >= 0) && req[own] && (m_hold[k] == mh[k]);
      m_to[k] = forced;
      if ((own >= 0) && req[own] && !forced) begin
         m_hold[k] = (m_hold[k] < mh[k]) ? m_hold[k] + 1 : m_hold[k];
      end else begin
         c = req;
         if (forced) c[own] = 1'b0;
         w = -1;
         if (!mode) begin
            for (int i = 0; i < 8; i++) if (c[i]) w = i;
         end else begin
            for (int j = 1; j <= 8; j++) if (w < 0 && c[(m_rr[k] + j) % 8]) w = (m_rr[k] + j) % 8;
         end
         m_own[k]  = w;
         m_hold[k] = (w >= 0) ? 1 : 0;
         if (w >= 0) m_rr[k] = w;
      end
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            m_own[k] = -1; m_hold[k] = 0; m_rr[k] = 7; m_to[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 3; k++) model_step(k);
      end
   end

   // Per-cycle comparison against the model, sampled just after the active edge
   logic [7:0] eg;
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 3; k++) begin
         eg = (m_own[k] < 0) ? 8'h00 : (8'h01 << m_own[k]);
         chk($sformatf("model_gnt%0d", k),   32'(gnt_w[k]),   32'(eg));
         chk($sformatf("model_id%0d", k),    32'(id_w[k]),    (m_own[k] < 0) ? 32'd0 : 32'(m_own[k]));
         chk($sformatf("model_valid%0d", k), 32'(valid_w[k]), 32'(m_own[k] >= 0));
         chk($sformatf("model_to%0d", k),    32'(to_w[k]),    32'(m_to[k]));
      end
   end

   task automatic chk_o(input string nm, input int k, input int id, input bit v, input bit t);
      logic [7:0] e;
      e = v ? (8'h01 << id) : 8'h00;
      chk({nm, "_gnt"},   32'(gnt_w[k]),   32'(e));
      chk({nm, "_id"},    32'(id_w[k]),    32'(id));
      chk({nm, "_valid"}, 32'(valid_w[k]), 32'(v));
      chk({nm, "_to"},    32'(to_w[k]),    32'(t));
   endtask

   task automatic do_reset();
      req = 8'h00;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   int r;
   initial begin
      rst = 1'b1; mode = 1'b0; req = 8'h00;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) chk_o("reset", k, 0, 1'b0, 1'b0);
      rst = 1'b0;

      // Fixed priority and zero-bubble handover
      req = 8'b0010_0110;
      @(negedge clk);
      chk("fp_gnt_lit", 32'(gnt_w[0]), 32'h20);
      chk_o("fp_first", 0, 5, 1'b1, 1'b0);
      req = 8'b0000_0110;
      @(negedge clk);
      chk_o("fp_handover", 0, 2, 1'b1, 1'b0);

      // Round-robin rotation with each owner dropping after two cycles
      do_reset();
      mode = 1'b1; req = 8'hFF;
      @(negedge clk);
      for (int e = 0; e < 9; e++) begin
         chk_o($sformatf("rr_rotate%0d", e), 0, e % 8, 1'b1, 1'b0);
         req = 8'hFF;
         @(negedge clk);
         req = 8'hFF & ~(8'h01 << (e % 8));
         @(negedge clk);
      end

      // Hold limit 4 with two contenders
      do_reset();
      mode = 1'b0; req = 8'b1000_0001;
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         chk_o("hold_own7", 1, 7, 1'b1, 1'b0);
         @(negedge clk);
      end
      chk_o("hold_to0", 1, 0, 1'b1, 1'b1);
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         chk_o("hold_own0", 1, 0, 1'b1, 1'b0);
         @(negedge clk);
      end
      chk_o("hold_to7", 1, 7, 1'b1, 1'b1);

      // Single requester timeout with limit 3
      do_reset();
      req = 8'b0000_1000;
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         chk_o("single_own", 2, 3, 1'b1, 1'b0);
         @(negedge clk);
      end
      chk_o("single_idle", 2, 0, 1'b0, 1'b1);
      @(negedge clk);
      chk_o("single_regrant", 2, 3, 1'b1, 1'b0);

      // Asynchronous reset mid-grant, then round-robin restarts at index 0
      do_reset();
      mode = 1'b0; req = 8'b0100_0000;
      @(negedge clk);
      chk_o("pre_rst", 0, 6, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 chk_o("async_rst", 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      mode = 1'b1; req = 8'hFF; rst = 1'b0;
      @(negedge clk);
      chk_o("rst_rr_first", 0, 0, 1'b1, 1'b0);

      // Mode switch while owner 2 holds the grant
      do_reset();
      mode = 1'b1; req = 8'b1000_0100;
      @(negedge clk);
      chk_o("ms_own2", 0, 2, 1'b1, 1'b0);
      mode = 1'b0;
      @(negedge clk);
      chk_o("ms_keep_a", 0, 2, 1'b1, 1'b0);
      @(negedge clk);
      chk_o("ms_keep_b", 0, 2, 1'b1, 1'b0);
      req = 8'b1000_0000;
      @(negedge clk);
      chk_o("ms_then7", 0, 7, 1'b1, 1'b0);

      // Randomized traffic, checked by the per-cycle model comparison
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         r = int'($urandom_range(0, 99));
         if (r < 20) req = 8'($urandom);
         else if (r < 35) req = req ^ (8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 31) == 0) mode = ~mode;
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
